// File: rtl/sha256_host_if.sv
// Big-endian message word stream into the SHA-256 host driver.
interface sha256_host_if;
   logic [31:0] in_data;
   logic        in_valid;
   logic        in_ready;
   logic        in_last;
   logic [2:0]  in_bytes;

   modport master (
      output in_data, in_valid, in_last, in_bytes,
      input  in_ready
   );

   modport slave (
      input  in_data, in_valid, in_last, in_bytes,
      output in_ready
   );
endinterface

// File: rtl/sha256_host.sv
// Host driver for the SHA-256 core: pads the message, feeds 512-bit
// blocks over the core bus and collects H0..H7 into a digest.
module sha256_host #(
   parameter int LEN_W  = 32,
   parameter int RD_LAT = 1
) (
   input  logic          clk,
   input  logic          rst,
   sha256_host_if.slave  msg,
   output logic [255:0]  digest,
   output logic          dig_valid,
   output logic          busy,
   output logic          core_rst,
   output logic          core_soc,
   output logic          core_rd,
   output logic [31:0]   core_dout,
   output logic          core_oe,
   input  logic [31:0]   core_din,
   input  logic          core_eoc
);
   localparam int RC_W = $clog2(RD_LAT + 9);

   typedef enum logic [3:0] {
      IDLE, FILL, PAD, CRST, SOC, SEND, WAIT, READ, DONE
   } state_t;

   state_t state, nxt;

   logic [31:0]      blk [16];
   logic [31:0]      padded [16];
   logic [31:0]      h [8];
   logic [4:0]       widx;
   logic [3:0]       sidx;
   logic [3:0]       lidx;
   logic [2:0]       lbytes;
   logic [RC_W-1:0]  rc;
   logic [LEN_W-1:0] cnt;
   logic             last_seen;
   logic             first_blk;
   logic             final_blk;
   logic             pad_next;
   logic             acc;
   logic [2:0]       nbytes;
   logic [63:0]      bitlen;
   logic [4:0]       pidx;
   logic             pad_fits;
   logic [31:0]      kmask;
   logic [31:0]      pword;

   assign msg.in_ready = !rst && (state == IDLE ||
                         (state == FILL && widx < 5'd16 && !last_seen));
   assign acc = msg.in_valid && msg.in_ready;
   assign nbytes = !msg.in_last ? 3'd4 :
                   (msg.in_bytes > 3'd4) ? 3'd4 : msg.in_bytes;

   assign busy      = state != IDLE;
   assign core_rst  = state == CRST;
   assign core_soc  = state == SOC;
   assign core_oe   = state == SEND;
   assign core_rd   = state == READ;
   assign dig_valid = state == DONE;
   assign core_dout = core_oe ? blk[sidx] : '0;

   // Pad byte sits after the last data byte; a full last word pushes it on.
   assign bitlen   = 64'({cnt, 3'b000});
   assign pidx     = {1'b0, lidx} + {4'b0, lbytes == 3'd4};
   assign pad_fits = pidx <= 5'd13;
   assign kmask    = ~(32'hFFFF_FFFF >> {lbytes, 3'b000});
   assign pword    = 32'h8000_0000 >> {lbytes, 3'b000};

   always_comb begin
      for (int i = 0; i < 16; i++) begin
         padded[i] = blk[i];
         if (4'(i) == lidx)
            padded[i] = (blk[i] & kmask) | pword;
         else if (5'(i) > {1'b0, lidx})
            padded[i] = (5'(i) == pidx) ? 32'h8000_0000 : '0;
      end
      if (pad_fits) begin
         padded[14] = bitlen[63:32];
         padded[15] = bitlen[31:0];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= nxt;
   end

   always_comb begin
      nxt = state;
      unique case (state)
         IDLE: if (acc) nxt = msg.in_last ? PAD : FILL;
         FILL: begin
            if (acc) begin
               if (msg.in_last)         nxt = PAD;
               else if (widx == 5'd15)  nxt = first_blk ? CRST : SOC;
            end
         end
         PAD:  nxt = first_blk ? CRST : SOC;
         CRST: nxt = SOC;
         SOC:  nxt = SEND;
         SEND: if (sidx == 4'd15) nxt = WAIT;
         WAIT: begin
            if (core_eoc) begin
               if (final_blk)      nxt = READ;
               else if (last_seen) nxt = SOC;
               else                nxt = FILL;
            end
         end
         READ: if (rc == RC_W'(RD_LAT + 7)) nxt = DONE;
         DONE: nxt = IDLE;
         default: nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 16; i++) blk[i] <= '0;
         for (int i = 0; i < 8; i++) h[i] <= '0;
         widx      <= '0;
         sidx      <= '0;
         lidx      <= '0;
         lbytes    <= '0;
         rc        <= '0;
         cnt       <= '0;
         last_seen <= 1'b0;
         first_blk <= 1'b0;
         final_blk <= 1'b0;
         pad_next  <= 1'b0;
         digest    <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (acc) begin
                  blk[0]    <= msg.in_data;
                  widx      <= 5'd1;
                  lidx      <= '0;
                  lbytes    <= nbytes;
                  cnt       <= LEN_W'(nbytes);
                  last_seen <= msg.in_last;
                  first_blk <= 1'b1;
                  final_blk <= 1'b0;
                  pad_next  <= 1'b0;
               end
            end
            FILL: begin
               if (acc) begin
                  blk[widx[3:0]] <= msg.in_data;
                  widx      <= widx + 5'd1;
                  lidx      <= widx[3:0];
                  lbytes    <= nbytes;
                  cnt       <= cnt + LEN_W'(nbytes);
                  last_seen <= msg.in_last;
               end
            end
            PAD: begin
               for (int i = 0; i < 16; i++) blk[i] <= padded[i];
               final_blk <= pad_fits;
               pad_next  <= pidx == 5'd16;
            end
            SOC: begin
               sidx      <= '0;
               first_blk <= 1'b0;
            end
            SEND: sidx <= sidx + 4'd1;
            WAIT: begin
               if (core_eoc) begin
                  rc <= '0;
                  // Length did not fit: the trailer goes out as its own block.
                  if (!final_blk && last_seen) begin
                     for (int i = 0; i < 16; i++) blk[i] <= '0;
                     blk[0]    <= pad_next ? 32'h8000_0000 : '0;
                     blk[14]   <= bitlen[63:32];
                     blk[15]   <= bitlen[31:0];
                     final_blk <= 1'b1;
                  end else if (!final_blk) begin
                     widx <= '0;
                  end
               end
            end
            READ: begin
               rc <= rc + RC_W'(1);
               if (rc >= RC_W'(RD_LAT))
                  h[3'(rc - RC_W'(RD_LAT))] <= core_din;
               if (rc == RC_W'(RD_LAT + 7))
                  digest <= {h[0], h[1], h[2], h[3],
                             h[4], h[5], h[6], core_din};
            end
            default: ;
         endcase
      end
   end
endmodule
